percept_sched: RTL and testbench
================================

# percept_sched

Opcode sequencer for the perceptron datapath. It listens to decoded UART bytes and waits for a frame addressed to this node (address byte, then command byte). It then walks the datapath through a fixed opcode sequence (clear, multiply-accumulate per input, threshold, optional weight update, transmit) using a valid/ack handshake. It sits between the UART receiver and the perceptron datapath, and replaces free-running opcode generation with a command-driven schedule.

## Interface
- N_INPUTS, 4, number of perceptron inputs/weights; 1 ≤ N_INPUTS ≤ 2^IDX_W
- IDX_W, 2, width of the input/weight index
- clk  input  1  clock, all logic on rising edge
- nRst  input  1  synchronous reset, active-low
- address  input  8  node address; static during operation
- rx_valid  input  1  one-cycle strobe, received byte on rx_data
- rx_data  input  8  received UART byte
- op_valid  output  1  op/op_idx hold a valid opcode
- op  output  3  opcode to datapath
- op_idx  output  IDX_W  input/weight index for MAC/UPD/WRST, else 0
- op_ack  input  1  datapath accepts current opcode
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse, sequence complete
- err  output  1  one-cycle pulse, reserved command or byte received while busy

## Operation
- Opcodes: 0 NOP, 1 CLR, 2 MAC, 3 THR, 4 UPD, 5 TX, 6 WRST, 7 unused (never issued).
- Frame FSM states: IDLE, CMD, RUN.
  - IDLE: on rx_valid, if rx_data == address or rx_data == 8'hFF (broadcast), go to CMD. Otherwise stay.
  - CMD: next rx_valid is the command byte. Mode is cmd[7:6]; cmd[5:0] is ignored.
- Modes:
  - 00 infer: CLR, MAC 0..N-1, THR, TX.
  - 01 train: CLR, MAC 0..N-1, THR, UPD 0..N-1, TX.
  - 10 weight reset: WRST 0..N-1 (no TX).
  - 11 reserved: pulse err, return to IDLE, no ops issued.
- RUN sub-states: S_CLR, S_MAC, S_THR, S_UPD, S_WRST, S_TX. Mode is latched at command accept.
- Index counter:
  - Advances only on op_valid && op_ack in S_MAC, S_UPD and S_WRST.
  - On ack with idx == N_INPUTS-1, it resets to 0 and the state advances. It never exceeds N_INPUTS-1.
- After the ack of the final op: done pulses, busy falls, FSM returns to IDLE.
- rx_valid while in RUN: byte discarded, err pulses, sequence unaffected.
- rx_valid while in CMD: always treated as the command byte, even if it equals address.

## Timing
- Reset values: op_valid 0, op 0, op_idx 0, busy 0, done 0, err 0; FSM IDLE, idx 0, mode 00.
- nRst low at any edge aborts any sequence immediately. There is no drain and no done pulse.
- Command byte accepted at edge t:
  - op_valid = 1 with the first op, and busy = 1, from cycle t+1.
  - Reserved mode: err = 1 in cycle t+1 only; busy stays 0.
- Handshake:
  - op, op_idx and op_valid are registered and held stable until the cycle where op_valid && op_ack.
  - The next op appears in the following cycle, with op_valid staying high back-to-back.
  - op_ack while op_valid = 0 is ignored.
- Throughput: one op per cycle with op_ack tied high.
  - Infer: N+3 cycles of op_valid.
  - Train: 2N+3 cycles.
  - Weight reset: N cycles.
- Completion: final op acked at edge e. At e+1, op_valid = 0, busy = 0 and done = 1; done = 0 at e+2.
- A new address byte is accepted from cycle e+1 onward.
- err for a byte during RUN is asserted in the cycle after the rx_valid edge.

## Test plan
- Infer, address 8'h12, N=4, op_ack tied 1:
  - Stimulus: rx 8'h12 then 8'h00.
  - Ops on consecutive cycles: CLR, MAC0, MAC1, MAC2, MAC3, THR, TX (7 cycles).
  - done pulses one cycle after the TX ack.
- Train 8'h40 with op_ack asserted 3 cycles after each op_valid:
  - Each op is held stable for 3 cycles.
  - Sequence: CLR, MAC0-3, THR, UPD0-3, TX; 11 acks total; busy high throughout.
- Address filtering:
  - rx 8'h34 then 8'h80 with address 8'h12: no op_valid.
  - Then rx 8'hFF, 8'h80: WRST0-3, done, no TX.
- Errors:
  - Command 8'hC0: err one cycle, busy stays 0.
  - During an infer run, inject rx_valid 8'h12: err one cycle, op sequence identical to the first scenario.
- Reset mid-operation:
  - nRst low for 1 cycle while op = MAC, op_idx = 2: next cycle all outputs 0.
  - Next frame 8'h12, 8'h00 restarts at CLR with op_idx 0.
- Boundary N_INPUTS=1, IDX_W=1, train mode: sequence CLR, MAC0, THR, UPD0, TX with op_idx always 0.

Source files
------------

// File: rtl/percept_sched_if.sv
// Handshake bundle between UART byte stream, opcode sequencer and perceptron datapath.
// master = sequencer side (consumes rx bytes and op_ack, drives opcodes); slave = environment side.
interface percept_sched_if #(
    parameter int IDX_W = 2
);
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             op_valid;
    logic [2:0]       op;
    logic [IDX_W-1:0] op_idx;
    logic             op_ack;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  op_ack,
        output op_valid,
        output op,
        output op_idx
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output op_ack,
        input  op_valid,
        input  op,
        input  op_idx
    );
endinterface

// File: rtl/percept_sched.sv
// Purpose: frame-driven opcode sequencer (address byte + command byte -> fixed op schedule).
// Latency: first op valid one cycle after the command byte; done one cycle after the final ack.
// Backpressure: each op held stable until op_ack; no op advances without acceptance.
module percept_sched #(
    parameter int N_INPUTS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [7:0]            address,
    percept_sched_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE, CMD, S_CLR, S_MAC, S_THR, S_UPD, S_WRST, S_TX
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_MAC  = 3'd2;
    localparam logic [2:0] OP_THR  = 3'd3;
    localparam logic [2:0] OP_UPD  = 3'd4;
    localparam logic [2:0] OP_TX   = 3'd5;
    localparam logic [2:0] OP_WRST = 3'd6;

    localparam logic [1:0] M_TRAIN = 2'b01;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       op_q;
    logic             op_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic fire;
    logic idx_last;
    logic addr_hit;

    assign fire     = op_valid_q && bus.op_ack;
    assign idx_last = (idx_q == IDX_LAST);
    assign addr_hit = (bus.rx_data == address) || (bus.rx_data == 8'hFF);

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            idx_q      <= '0;
            op_q       <= OP_NOP;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.rx_valid && addr_hit) begin
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    // Any byte here is the command, even one matching the node address.
                    if (bus.rx_valid) begin
                        mode_q <= bus.rx_data[7:6];
                        idx_q  <= '0;
                        case (bus.rx_data[7:6])
                            2'b00, 2'b01: begin
                                state_q    <= S_CLR;
                                op_q       <= OP_CLR;
                                op_valid_q <= 1'b1;
                                busy_q     <= 1'b1;
                            end
                            2'b10: begin
                                state_q    <= S_WRST;
                                op_q       <= OP_WRST;
                                op_valid_q <= 1'b1;
                                busy_q     <= 1'b1;
                            end
                            default: begin
                                state_q <= IDLE;
                                err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    // Bytes arriving mid-sequence are dropped and flagged.
                    if (bus.rx_valid) begin
                        err_q <= 1'b1;
                    end
                    if (fire) begin
                        case (state_q)
                            S_CLR: begin
                                state_q <= S_MAC;
                                op_q    <= OP_MAC;
                            end
                            S_MAC: begin
                                if (idx_last) begin
                                    idx_q   <= '0;
                                    state_q <= S_THR;
                                    op_q    <= OP_THR;
                                end else begin
                                    idx_q <= idx_q + IDX_ONE;
                                end
                            end
                            S_THR: begin
                                if (mode_q == M_TRAIN) begin
                                    state_q <= S_UPD;
                                    op_q    <= OP_UPD;
                                end else begin
                                    state_q <= S_TX;
                                    op_q    <= OP_TX;
                                end
                            end
                            S_UPD: begin
                                if (idx_last) begin
                                    idx_q   <= '0;
                                    state_q <= S_TX;
                                    op_q    <= OP_TX;
                                end else begin
                                    idx_q <= idx_q + IDX_ONE;
                                end
                            end
                            S_WRST: begin
                                if (idx_last) begin
                                    idx_q      <= '0;
                                    state_q    <= IDLE;
                                    op_q       <= OP_NOP;
                                    op_valid_q <= 1'b0;
                                    busy_q     <= 1'b0;
                                    done_q     <= 1'b1;
                                end else begin
                                    idx_q <= idx_q + IDX_ONE;
                                end
                            end
                            default: begin
                                idx_q      <= '0;
                                state_q    <= IDLE;
                                op_q       <= OP_NOP;
                                op_valid_q <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.op_valid = op_valid_q;
    assign bus.op       = op_q;
    assign bus.op_idx   = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_percept_sched.sv
// Bench for percept_sched: directed scenarios plus randomized frames against an op-list model.
module tb_percept_sched;

    logic       clk = 1'b0;
    logic       nRst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       op_ack;
    logic       busy_a, done_a, err_a;
    logic       busy_b, done_b, err_b;
    logic       sel;

    always #5 clk = ~clk;

    percept_sched_if #(.IDX_W(2)) ia ();
    percept_sched_if #(.IDX_W(1)) ib ();

    assign ia.rx_valid = rx_valid;
    assign ia.rx_data  = rx_data;
    assign ia.op_ack   = op_ack;
    assign ib.rx_valid = rx_valid;
    assign ib.rx_data  = rx_data;
    assign ib.op_ack   = op_ack;

    percept_sched #(.N_INPUTS(4), .IDX_W(2)) dut_a (
        .clk(clk), .nRst(nRst), .address(8'h12), .bus(ia.master),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    percept_sched #(.N_INPUTS(1), .IDX_W(1)) dut_b (
        .clk(clk), .nRst(nRst), .address(8'h55), .bus(ib.master),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    logic       m_valid, m_busy, m_done, m_err;
    logic [2:0] m_op;
    logic [1:0] m_idx;
    assign m_valid = sel ? ib.op_valid : ia.op_valid;
    assign m_op    = sel ? ib.op       : ia.op;
    assign m_idx   = sel ? {1'b0, ib.op_idx} : ia.op_idx;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_err   = sel ? err_b  : err_a;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected op list, each entry encoded as opcode*16 + index.
    task automatic build(input int mode, input int n);
        exp_q.delete();
        if (mode == 2) begin
            for (int i = 0; i < n; i++) exp_q.push_back(6 * 16 + i);
        end else if (mode < 2) begin
            exp_q.push_back(1 * 16);
            for (int i = 0; i < n; i++) exp_q.push_back(2 * 16 + i);
            exp_q.push_back(3 * 16);
            if (mode == 1) for (int i = 0; i < n; i++) exp_q.push_back(4 * 16 + i);
            exp_q.push_back(5 * 16);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        op_ack   = 1'($urandom_range(0, 1));
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_op"},    m_op,    0);
        chk({tag, "_idx"},   m_idx,   0);
        chk({tag, "_busy"},  m_busy,  0);
        chk({tag, "_done"},  m_done,  0);
        chk({tag, "_err"},   m_err,   0);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] cmd, input bit hit,
                         input int mind, input int maxd, input bit inject, input int n);
        int mode;
        int j_inj;
        int d;
        bit pend;
        mode = int'(cmd[7:6]);
        send(a);
        send(cmd);
        if (!hit) begin
            chk("miss_valid", m_valid, 0);
            chk("miss_busy",  m_busy,  0);
            chk("miss_err",   m_err,   0);
            return;
        end
        if (mode == 3) begin
            chk("rsv_err",   m_err,   1);
            chk("rsv_busy",  m_busy,  0);
            chk("rsv_valid", m_valid, 0);
            tick();
            chk("rsv_err_clr", m_err,  0);
            chk("rsv_busy2",   m_busy, 0);
            return;
        end
        build(mode, n);
        j_inj = (inject && exp_q.size() > 2) ? $urandom_range(1, exp_q.size() - 2) : -1;
        pend = 1'b0;
        foreach (exp_q[j]) begin
            d = $urandom_range(mind, maxd);
            for (int k = 0; k <= d; k++) begin
                chk("valid", m_valid, 1);
                chk("op",    m_op,    exp_q[j] / 16);
                chk("idx",   m_idx,   exp_q[j] % 16);
                chk("busy",  m_busy,  1);
                chk("done",  m_done,  0);
                chk("err",   m_err,   32'(pend));
                pend     = (j == j_inj) && (k == 0);
                rx_valid = pend;
                rx_data  = a;
                op_ack   = (k == d);
                tick();
            end
        end
        rx_valid = 1'b0;
        op_ack   = 1'($urandom_range(0, 1));
        chk("end_valid", m_valid, 0);
        chk("end_busy",  m_busy,  0);
        chk("end_done",  m_done,  1);
        chk("end_err",   m_err,   0);
        tick();
        chk("post_done",  m_done,  0);
        chk("post_valid", m_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a;
        logic [1:0] md;
        int         r;
        bit         hit;

        sel      = 1'b0;
        nRst     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        op_ack   = 1'b0;
        tick();
        tick();
        chk_idle("rst");
        nRst = 1'b1;
        tick();

        frame(8'h12, 8'h00, 1'b1, 0, 0, 1'b0, 4);
        frame(8'h12, 8'h40, 1'b1, 2, 2, 1'b0, 4);
        frame(8'h34, 8'h80, 1'b0, 0, 0, 1'b0, 4);
        frame(8'hFF, 8'h80, 1'b1, 0, 1, 1'b0, 4);
        frame(8'h12, 8'hC0, 1'b1, 0, 0, 1'b0, 4);
        frame(8'h12, 8'h00, 1'b1, 0, 0, 1'b1, 4);
        frame(8'h12, 8'h12, 1'b1, 0, 0, 1'b0, 4);

        // Abort mid-sequence while MAC index 2 is presented.
        send(8'h12);
        send(8'h00);
        op_ack = 1'b1;
        repeat (3) tick();
        chk("pre_rst_op",  m_op,  2);
        chk("pre_rst_idx", m_idx, 2);
        nRst   = 1'b0;
        op_ack = 1'b0;
        tick();
        nRst = 1'b1;
        chk_idle("abort");
        frame(8'h12, 8'h00, 1'b1, 0, 0, 1'b0, 4);

        for (int it = 0; it < 25; it++) begin
            r  = $urandom_range(0, 2);
            md = 2'($urandom_range(0, 3));
            if (r == 0) a = 8'h12;
            else if (r == 1) a = 8'hFF;
            else begin
                do a = 8'($urandom); while (a == 8'h12 || a == 8'hFF);
            end
            hit = (r != 2);
            frame(a, hit ? {md, 6'($urandom)} : {md, 6'b0}, hit,
                  0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 4);
        end

        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        sel  = 1'b1;
        chk_idle("rst_b");
        tick();
        frame(8'h55, 8'h40, 1'b1, 0, 0, 1'b0, 1);
        for (int it = 0; it < 6; it++) begin
            md = 2'($urandom_range(0, 3));
            frame(8'h55, {md, 6'($urandom)}, 1'b1, 0, $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
